mul_operand_feeder: RTL and testbench



---
 rtl/mul_operand_feeder.sv | 136 +++++++++++++
 tb/tb_mul_operand_feeder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_operand_feeder.sv
// Operand feeder for the repeated-addition multiplier: 2-entry {A,B} FIFO plus a
// sequencer driving start, A, A, B onto the shared bus. Optional macro FEED_WATCHDOG_EN adds a WAIT timeout.
module mul_operand_feeder #(
  parameter int WIDTH       = 16,
  parameter int WDOG_CYCLES = 70000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] bus_out,
  output logic             start,
  input  logic             done,
  output logic             busy,
  output logic             err,
  output logic [7:0]       job_cnt
);

  typedef enum logic [2:0] {S_IDLE, S_START, S_LOADA, S_LOADB, S_WAIT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       count_q, count_d;
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [7:0]       job_cnt_q, job_cnt_d;
  logic [WIDTH-1:0] mem_a_q [2];
  logic [WIDTH-1:0] mem_a_d [2];
  logic [WIDTH-1:0] mem_b_q [2];
  logic [WIDTH-1:0] mem_b_d [2];
  logic [WIDTH-1:0] head_a, head_b;
  logic             push, pop, done_ok, timeout;

  assign in_ready = (count_q != 2'd2);
  assign push     = in_valid && in_ready;
  assign done_ok  = (state_q == S_WAIT) && done;
  assign pop      = done_ok || timeout;
  assign head_a   = mem_a_q[rd_ptr_q];
  assign head_b   = mem_b_q[rd_ptr_q];
  assign job_cnt  = job_cnt_q;
  assign err      = timeout;

`ifdef FEED_WATCHDOG_EN
  localparam int WDOG_W = $clog2(WDOG_CYCLES + 1);

  logic [WDOG_W-1:0] wdog_q, wdog_d;

  // Counter is zero in the first WAIT cycle, so the timeout fires in WAIT cycle WDOG_CYCLES.
  always_comb begin
    wdog_d = wdog_q;
    if (state_q == S_LOADB) begin
      wdog_d = '0;
    end else if (state_q == S_WAIT) begin
      wdog_d = wdog_q + 1'b1;
    end
  end

  assign timeout = (state_q == S_WAIT) && !done && (wdog_q == WDOG_W'(WDOG_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wdog_q <= '0;
    end else begin
      wdog_q <= wdog_d;
    end
  end
`else
  logic unused_wdog_cfg;
  assign unused_wdog_cfg = (WDOG_CYCLES != 0);
  assign timeout         = 1'b0;
`endif

  always_comb begin
    mem_a_d  = mem_a_q;
    mem_b_d  = mem_b_q;
    wr_ptr_d = wr_ptr_q ^ push;
    rd_ptr_d = rd_ptr_q ^ pop;
    count_d  = count_q + 2'(push) - 2'(pop);
    if (push) begin
      mem_a_d[wr_ptr_q] = in_a;
      mem_b_d[wr_ptr_q] = in_b;
    end
    job_cnt_d = job_cnt_q + 8'(done_ok);
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (count_q != 2'd0) state_d = S_START;
      S_START: state_d = S_LOADA;
      S_LOADA: state_d = S_LOADB;
      S_LOADB: state_d = S_WAIT;
      S_WAIT:  if (pop) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    start   = 1'b0;
    bus_out = '0;
    busy    = (state_q != S_IDLE);
    case (state_q)
      S_START: begin
        start   = 1'b1;
        bus_out = head_a;
      end
      S_LOADA: bus_out = head_a;
      S_LOADB: bus_out = head_b;
      default: bus_out = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      count_q   <= 2'd0;
      wr_ptr_q  <= 1'b0;
      rd_ptr_q  <= 1'b0;
      job_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      job_cnt_q <= job_cnt_d;
    end
  end

  // Payload storage carries no reset; it is only observed through an occupied head entry.
  always_ff @(posedge clk) begin
    mem_a_q <= mem_a_d;
    mem_b_q <= mem_b_d;
  end

endmodule

// File: tb/tb_mul_operand_feeder.sv
// Directed bench for mul_operand_feeder: a per-cycle vector table plus hand-written
// sequences for back-pressure, reset mid-job, counter wrap and the optional watchdog.
module tb_mul_operand_feeder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] in_a = '0;
  logic [15:0] in_b = '0;
  logic [15:0] bus_out;
  logic        start;
  logic        done = 1'b0;
  logic        busy;
  logic        err;
  logic [7:0]  job_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  logic [15:0] la[$];
  logic [15:0] lb[$];
  logic [15:0] cap_a;
  int          phase = 0;

  mul_operand_feeder #(.WIDTH(16), .WDOG_CYCLES(20)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .bus_out(bus_out), .start(start),
    .done(done), .busy(busy), .err(err), .job_cnt(job_cnt)
  );

  always #5 clk = ~clk;

  // Launch recorder: A is taken in the start cycle, B two cycles later.
  always @(negedge clk) begin
    if (rst) begin
      phase <= 0;
    end else if (start) begin
      cap_a <= bus_out;
      phase <= 1;
    end else if (phase == 1) begin
      phase <= 2;
    end else if (phase == 2) begin
      la.push_back(cap_a);
      lb.push_back(bus_out);
      phase <= 0;
    end
  end

  typedef struct {
    logic        v;
    logic [15:0] a;
    logic [15:0] b;
    logic        d;
    logic        e_start;
    logic [15:0] e_bus;
    logic        e_busy;
    logic        e_ready;
    logic [7:0]  e_job;
  } vec_t;

  function automatic vec_t mk(int v, int a, int b, int d, int s, int bus, int bz, int rdy, int job);
    vec_t r;
    r.v = v[0]; r.a = 16'(a); r.b = 16'(b); r.d = d[0];
    r.e_start = s[0]; r.e_bus = 16'(bus); r.e_busy = bz[0]; r.e_ready = rdy[0]; r.e_job = 8'(job);
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1'b1; in_a = a; in_b = b;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic complete_one();
    int n = 0;
    while (!start && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("start_seen", {31'd0, start}, 32'd1);
    repeat (3) @(negedge clk);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
  endtask

  vec_t tbl[23];
  int   base;
  int   n0;

  initial begin
    tbl[0]  = mk(1, 7, 3, 0, 0, 0, 0, 1, 0);
    tbl[1]  = mk(0, 0, 0, 0, 1, 7, 1, 1, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 7, 1, 1, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 3, 1, 1, 0);
    for (int i = 4; i <= 12; i++) tbl[i] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0);
    tbl[13] = mk(0, 0, 0, 1, 0, 0, 0, 1, 1);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
    tbl[15] = mk(1, 4, 6, 0, 0, 0, 0, 1, 1);
    tbl[16] = mk(0, 0, 0, 1, 1, 4, 1, 1, 1);
    tbl[17] = mk(0, 0, 0, 1, 0, 4, 1, 1, 1);
    tbl[18] = mk(0, 0, 0, 1, 0, 6, 1, 1, 1);
    tbl[19] = mk(0, 0, 0, 1, 0, 0, 1, 1, 1);
    tbl[20] = mk(0, 0, 0, 0, 0, 0, 1, 1, 1);
    tbl[21] = mk(0, 0, 0, 1, 0, 0, 0, 1, 2);
    tbl[22] = mk(0, 0, 0, 0, 0, 0, 0, 1, 2);

    repeat (2) @(negedge clk);
    chk("rst_bus", bus_out, 0);
    chk("rst_start", start, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_ready", in_ready, 1);
    chk("rst_job", job_cnt, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 23; i++) begin
      in_valid = tbl[i].v; in_a = tbl[i].a; in_b = tbl[i].b; done = tbl[i].d;
      @(negedge clk);
      chk($sformatf("v%0d_start", i), start, tbl[i].e_start);
      chk($sformatf("v%0d_bus", i), bus_out, tbl[i].e_bus);
      chk($sformatf("v%0d_busy", i), busy, tbl[i].e_busy);
      chk($sformatf("v%0d_ready", i), in_ready, tbl[i].e_ready);
      chk($sformatf("v%0d_job", i), job_cnt, tbl[i].e_job);
      chk($sformatf("v%0d_err", i), err, 0);
    end
    in_valid = 1'b0; done = 1'b0;

    base = la.size();
    in_valid = 1'b1; in_a = 16'd5; in_b = 16'd2;
    @(negedge clk);
    chk("bp_ready_after1", in_ready, 1);
    in_a = 16'd9; in_b = 16'd4;
    @(negedge clk);
    chk("bp_ready_after2", in_ready, 0);
    chk("bp_start1", start, 1);
    chk("bp_bus1", bus_out, 5);
    in_a = 16'd1; in_b = 16'd1;
    repeat (6) @(negedge clk);
    chk("bp_held_ready", in_ready, 0);
    chk("bp_wait_busy", busy, 1);
    chk("bp_wait_err", err, 0);
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    chk("bp_pop_ready", in_ready, 1);
    chk("bp_pop_idle", busy, 0);
    chk("bp_pop_job", job_cnt, 3);
    @(negedge clk);
    chk("bp_third_taken", in_ready, 0);
    chk("bp_start2", start, 1);
    chk("bp_bus2", bus_out, 9);
    in_valid = 1'b0;
    complete_one();
    complete_one();
    chk("bp_job_total", job_cnt, 5);
    chk("bp_launch_n", la.size(), base + 3);
    if (la.size() >= base + 3) begin
      chk("bp_a0", la[base], 5);     chk("bp_b0", lb[base], 2);
      chk("bp_a1", la[base + 1], 9); chk("bp_b1", lb[base + 1], 4);
      chk("bp_a2", la[base + 2], 1); chk("bp_b2", lb[base + 2], 1);
    end

    @(negedge clk);
    in_valid = 1'b1; in_a = 16'd21; in_b = 16'd22;
    @(negedge clk);
    in_a = 16'd23; in_b = 16'd24;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mr_loadb_bus", bus_out, 22);
    chk("mr_full", in_ready, 0);
    #1 rst = 1'b1;
    #1;
    chk("mr_start", start, 0);
    chk("mr_bus", bus_out, 0);
    chk("mr_ready", in_ready, 1);
    chk("mr_busy", busy, 0);
    chk("mr_job", job_cnt, 0);
    @(negedge clk);
    rst = 1'b0;
    n0 = la.size();
    repeat (6) @(negedge clk);
    chk("mr_no_launch_busy", busy, 0);
    chk("mr_no_launch_n", la.size(), n0);
    chk("mr_empty_ready", in_ready, 1);

    for (int i = 0; i < 256; i++) begin
      push_pair(16'(i), 16'(255 - i));
      complete_one();
      chk($sformatf("wrap_job%0d", i), job_cnt, (i + 1) % 256);
      chk($sformatf("wrap_a%0d", i), la[la.size() - 1], i);
      chk($sformatf("wrap_b%0d", i), lb[lb.size() - 1], 255 - i);
    end

`ifdef FEED_WATCHDOG_EN
    in_valid = 1'b1; in_a = 16'd11; in_b = 16'd1;
    @(negedge clk);
    in_a = 16'd12; in_b = 16'd2;
    @(negedge clk);
    in_valid = 1'b0;
    chk("wd_start1", start, 1);
    @(negedge clk);
    @(negedge clk);
    repeat (19) @(negedge clk);
    chk("wd_no_err_early", err, 0);
    @(negedge clk);
    chk("wd_err", err, 1);
    @(negedge clk);
    chk("wd_err_pulse", err, 0);
    chk("wd_idle", busy, 0);
    chk("wd_job_kept", job_cnt, 0);
    @(negedge clk);
    chk("wd_next_start", start, 1);
    chk("wd_next_bus", bus_out, 12);
    @(negedge clk);
    @(negedge clk);
    repeat (20) @(negedge clk);
    done = 1'b1;
    #1;
    chk("wd_done_wins_err", err, 0);
    @(negedge clk);
    done = 1'b0;
    chk("wd_done_job", job_cnt, 1);
    chk("wd_done_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, limit 500000");
    $fatal(1, "timeout");
  end

endmodule
